// File: rtl/tick_sched_pkg.sv
// Shared types and constants for the tick scheduler timebase.
package tick_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BASE,
        LOAD
    } cfg_state_e;

    localparam int DEFAULT_PERIOD_DEF = 1000;

    function automatic bit params_ok(input int prescale, input int n_ch,
                                     input int period_w, input int default_period);
        bit fits;
        fits = (period_w >= 31) || ((default_period >> period_w) == 0);
        return (prescale >= 2) && (n_ch >= 2) && (period_w >= 1) &&
               (default_period != 0) && fits;
    endfunction

endpackage

// File: rtl/tick_channel.sv
// One channel divider: counts base ticks and flags the P-th one; a load
// rewrites period and phase and takes priority over counting.
module tick_channel #(
    parameter int PERIOD_W       = 16,
    parameter int DEFAULT_PERIOD = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pz,
    input  logic                run,
    input  logic                load,
    input  logic [PERIOD_W-1:0] load_period,
    output logic                fire
);

    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] cnt;
    logic                active;

    assign active = run && (period != '0);
    assign fire   = pz && active && (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period <= PERIOD_W'(DEFAULT_PERIOD);
            cnt    <= PERIOD_W'(DEFAULT_PERIOD - 1);
        end else if (load) begin
            period <= load_period;
            cnt    <= (load_period == '0) ? '0 : load_period - PERIOD_W'(1);
        end else if (pz && active) begin
            cnt    <= (cnt == '0) ? period - PERIOD_W'(1) : cnt - PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/tick_scheduler.sv
// Prescaler, run-time channel configuration FSM and registered tick outputs.
// Define TICK_SCHED_SYNC_LOAD_EN to align channel loads to base-tick boundaries.
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int PRESCALE       = 50000,
    parameter int N_CH           = 4,
    parameter int PERIOD_W       = 16,
    parameter int DEFAULT_PERIOD = DEFAULT_PERIOD_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [N_CH-1:0]         ch_en,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [$clog2(N_CH)-1:0] cfg_ch,
    input  logic [PERIOD_W-1:0]     cfg_period,
    output logic                    base_tick,
    output logic [N_CH-1:0]         tick
);

    localparam int CH_W = $clog2(N_CH);
    localparam int PS_W = $clog2(PRESCALE);

    if (!params_ok(PRESCALE, N_CH, PERIOD_W, DEFAULT_PERIOD)) begin : g_param_check
        $error("tick_scheduler: invalid parameter set");
    end

    logic [PS_W-1:0]     ps_cnt;
    logic                pz;
    cfg_state_e          state_q;
    cfg_state_e          state_d;
    logic                load_go;
    logic [CH_W-1:0]     ch_q;
    logic [PERIOD_W-1:0] period_q;
    logic [N_CH-1:0]     fire;
    logic [N_CH-1:0]     load;
    logic [N_CH-1:0]     tick_d;

    assign pz = enable && (ps_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_cnt <= PS_W'(PRESCALE - 1);
        end else if (pz) begin
            ps_cnt <= PS_W'(PRESCALE - 1);
        end else if (enable) begin
            ps_cnt <= ps_cnt - PS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            period_q <= '0;
        end else begin
            state_q <= state_d;
            if (cfg_valid && cfg_ready) begin
                ch_q     <= cfg_ch;
                period_q <= cfg_period;
            end
        end
    end

    // base_tick is the registered pz, so seeing it in WAIT_BASE means the
    // boundary has just passed and the load lands one cycle later.
    always_comb begin
        state_d   = state_q;
        cfg_ready = 1'b0;
        load_go   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
`ifdef TICK_SCHED_SYNC_LOAD_EN
                    state_d = WAIT_BASE;
`else
                    state_d = LOAD;
`endif
                end
            end
            WAIT_BASE: begin
                if (base_tick || !enable) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                load_go = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Out-of-range channel indices match no channel, so such writes are dropped.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign load[i] = load_go && (ch_q == CH_W'(i));

        tick_channel #(
            .PERIOD_W       (PERIOD_W),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_channel (
            .clk         (clk),
            .rst_n       (rst_n),
            .pz          (pz),
            .run         (ch_en[i]),
            .load        (load[i]),
            .load_period (period_q),
            .fire        (fire[i])
        );

`ifdef TICK_SCHED_SYNC_LOAD_EN
        assign tick_d[i] = fire[i];
`else
        assign tick_d[i] = fire[i] && !load[i];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_tick <= 1'b0;
            tick      <= '0;
        end else begin
            base_tick <= pz;
            tick      <= tick_d;
        end
    end

endmodule
